// File: rtl/fifo_pkg.sv
// Shared definitions for the sync_fifo reader slice: buffer occupancy encoding,
// default word width and the read-issue room test.
package fifo_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;

    typedef logic [1:0] occ_t;

    localparam occ_t OCC_EMPTY = 2'd0;
    localparam occ_t OCC_ONE   = 2'd1;
    localparam occ_t OCC_TWO   = 2'd2;

    // True when buffered plus returning words, less the one leaving, stay below two.
    function automatic logic can_issue(input occ_t occ, input logic inflight, input logic pop);
        return ({1'b0, occ} + {2'b00, inflight}) < ({1'b0, OCC_TWO} + {2'b00, pop});
    endfunction

endpackage

// File: rtl/sync_fifo_reader_if.sv
// FIFO read-side and output stream signals of the sync_fifo reader.
// master is the reader's view, slave is the FIFO/consumer side.
interface sync_fifo_reader_if #(parameter int DATA_WIDTH = fifo_pkg::DEFAULT_DATA_WIDTH);

    logic                  fifo_empty;
    logic                  fifo_read_en;
    logic [DATA_WIDTH-1:0] fifo_data_out;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;

    modport master (
        input  fifo_empty,
        input  fifo_data_out,
        input  m_ready,
        output fifo_read_en,
        output m_valid,
        output m_data
    );

    modport slave (
        output fifo_empty,
        output fifo_data_out,
        output m_ready,
        input  fifo_read_en,
        input  m_valid,
        input  m_data
    );

endinterface

// File: rtl/fifo_skid_buf2.sv
// Two-entry output buffer: storage, head/tail pointers and occupancy count.
// clear empties the buffer synchronously; storage is zeroed only by reset.
module fifo_skid_buf2 import fifo_pkg::*; #(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output occ_t                  occ
);

    logic [DATA_WIDTH-1:0] mem [2];
    logic                  wr_ptr;
    logic                  rd_ptr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= OCC_EMPTY;
        end else if (clear) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= OCC_EMPTY;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            // Simultaneous push and pop leaves the count unchanged.
            if (push && !pop) begin
                occ <= occ + 2'd1;
            end else if (pop && !push) begin
                occ <= occ - 2'd1;
            end
        end
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/sync_fifo_reader.sv
// Turns the sync_fifo read port (one-cycle read latency) into a valid/ready stream.
// Define SYNC_FIFO_READER_CNT_EN to add the 16-bit word_count output.
module sync_fifo_reader import fifo_pkg::*; #(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    sync_fifo_reader_if.master bus
`ifdef SYNC_FIFO_READER_CNT_EN
    ,
    output logic [15:0]        word_count
`endif
);

    logic inflight;
    logic drop;
    logic pop;
    logic capture;
    logic read_en;
    occ_t occ;

    assign pop     = bus.m_valid & bus.m_ready;
    assign drop    = inflight & flush;
    assign capture = inflight & ~drop;

    // Gated by reset so the strobe drops the instant reset asserts, not at the next edge.
    assign read_en          = reset & ~bus.fifo_empty & ~flush & can_issue(occ, inflight, pop);
    assign bus.fifo_read_en = read_en;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inflight <= 1'b0;
        end else begin
            inflight <= read_en;
        end
    end

    fifo_skid_buf2 #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
        .clk       (clk),
        .reset     (reset),
        .clear     (flush),
        .push      (capture),
        .push_data (bus.fifo_data_out),
        .pop       (pop),
        .head_data (bus.m_data),
        .occ       (occ)
    );

    assign bus.m_valid = (occ != OCC_EMPTY);

`ifdef SYNC_FIFO_READER_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_count <= 16'd0;
        end else if (flush) begin
            word_count <= 16'd0;
        end else if (pop) begin
            word_count <= word_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_reader.sv
// Randomised and directed bench for sync_fifo_reader against a word-order scoreboard
// and an emulated sync_fifo; covers word_count when SYNC_FIFO_READER_CNT_EN is defined.
module tb_sync_fifo_reader;

    localparam int DW        = 8;
    localparam int MEM_DEPTH = 1024;

    logic clk = 1'b0;
    logic reset;
    logic flush;

    sync_fifo_reader_if #(.DATA_WIDTH(DW)) bus ();

`ifdef SYNC_FIFO_READER_CNT_EN
    logic [15:0] word_count;
    logic [15:0] modelCount = 16'd0;
`endif

    sync_fifo_reader #(.DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
`ifdef SYNC_FIFO_READER_CNT_EN
        ,
        .word_count (word_count)
`endif
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Emulated sync_fifo: words pushed by the stimulus, one popped per sampled read strobe.
    logic [DW-1:0] srcMem [MEM_DEPTH];
    int            pushCount   = 0;
    int            popCount    = 0;
    logic          readPending = 1'b0;

    assign bus.fifo_empty = (pushCount == popCount);

    always @(negedge clk) readPending <= bus.fifo_read_en;

    always @(posedge clk) begin
        if (readPending && reset) begin
            bus.fifo_data_out <= srcMem[popCount % MEM_DEPTH];
            popCount          <= popCount + 1;
        end
    end

    task automatic pushWord(input logic [DW-1:0] w);
        srcMem[pushCount % MEM_DEPTH] = w;
        pushCount = pushCount + 1;
    endtask

    // Scoreboard: words read and not yet delivered, in FIFO order; flush and reset discard them.
    logic [DW-1:0] expQ [$];
    int            readCount = 0;
    logic          prevHold  = 1'b0;
    logic [DW-1:0] prevData  = '0;

    always @(negedge clk or negedge reset) begin
        if (!reset) begin
            expQ.delete();
            prevHold = 1'b0;
`ifdef SYNC_FIFO_READER_CNT_EN
            modelCount = 16'd0;
`endif
        end else begin
            if (prevHold) begin
                checkOutput("hold_valid", bus.m_valid, 1);
                checkOutput("hold_data", bus.m_data, prevData);
            end
`ifdef SYNC_FIFO_READER_CNT_EN
            checkOutput("word_count", word_count, modelCount);
`endif
            if (bus.fifo_read_en) checkOutput("rd_not_empty", bus.fifo_empty, 0);
            if (flush) checkOutput("rd_in_flush", bus.fifo_read_en, 0);
            if (bus.m_valid && bus.m_ready) begin
                checkOutput("pop_has_ref", expQ.size() != 0, 1);
                if (expQ.size() != 0) checkOutput("pop_data", bus.m_data, expQ.pop_front());
`ifdef SYNC_FIFO_READER_CNT_EN
                modelCount = modelCount + 16'd1;
`endif
            end
            if (flush) begin
                expQ.delete();
`ifdef SYNC_FIFO_READER_CNT_EN
                modelCount = 16'd0;
`endif
            end
            if (bus.fifo_read_en) begin
                readCount++;
                expQ.push_back(srcMem[popCount % MEM_DEPTH]);
            end
            prevHold = bus.m_valid && !bus.m_ready && !flush;
            prevData = bus.m_data;
        end
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic ready, input logic fl);
        bus.m_ready = ready;
        flush       = fl;
    endtask

    task automatic doReset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // Counts sampled cycles with m_valid low before it rises.
    task automatic waitForValid(input string tag, input int limit, output int cycles);
        cycles = 0;
        @(negedge clk);
        while (bus.m_valid !== 1'b1 && cycles < limit) begin
            cycles++;
            @(negedge clk);
        end
        checkOutput({tag, "_seen"}, bus.m_valid, 1);
    endtask

    task automatic drain();
        int quiet = 0;
        int n     = 0;
        applyStimulus(1'b1, 1'b0);
        while (quiet < 4 && n < 2000) begin
            nextCycle();
            n++;
            if (bus.fifo_empty && !bus.m_valid && !bus.fifo_read_en) quiet++;
            else quiet = 0;
        end
        checkOutput("drain_done", quiet >= 4, 1);
        checkOutput("drain_leftover", expQ.size(), 0);
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cyc;
        int r0;
        int run;

        reset = 1'b0;
        flush = 1'b0;
        bus.m_ready = 1'b0;
        #2;
        checkOutput("rst_valid", bus.m_valid, 0);
        checkOutput("rst_rd_en", bus.fifo_read_en, 0);
        checkOutput("rst_data", bus.m_data, 0);
        doReset();

        $display("[TB] single word");
        nextCycle();
        applyStimulus(1'b1, 1'b0);
        pushWord(8'h3C);
        @(negedge clk);
        checkOutput("single_rd_en", bus.fifo_read_en, 1);
        checkOutput("single_valid_c0", bus.m_valid, 0);
        @(negedge clk);
        checkOutput("single_rd_once", bus.fifo_read_en, 0);
        checkOutput("single_valid_c1", bus.m_valid, 0);
        @(negedge clk);
        checkOutput("single_valid_c2", bus.m_valid, 1);
        checkOutput("single_data", bus.m_data, 8'h3C);
        @(negedge clk);
        checkOutput("single_valid_c3", bus.m_valid, 0);

        $display("[TB] streaming");
        nextCycle();
        r0 = readCount;
        for (int i = 0; i < 16; i++) pushWord(DW'(i));
        waitForValid("stream", 10, cyc);
        checkOutput("stream_latency", cyc, 2);
        run = 0;
        while (bus.m_valid && run < 40) begin
            run++;
            @(negedge clk);
        end
        checkOutput("stream_run", run, 16);
        drain();
        checkOutput("stream_reads", readCount - r0, 16);

        $display("[TB] backpressure");
        nextCycle();
        applyStimulus(1'b0, 1'b0);
        r0 = readCount;
        for (int i = 0; i < 5; i++) pushWord(DW'(8'hA0 + i));
        repeat (6) nextCycle();
        checkOutput("bp_reads", readCount - r0, 2);
        checkOutput("bp_valid", bus.m_valid, 1);
        checkOutput("bp_head", bus.m_data, 8'hA0);
        drain();
        checkOutput("bp_total_reads", readCount - r0, 5);

        $display("[TB] flush with read in flight");
        nextCycle();
        applyStimulus(1'b0, 1'b0);
        pushWord(8'h51);
        waitForValid("fl_setup", 10, cyc);
        nextCycle();
        pushWord(8'h52);
        pushWord(8'h53);
        @(negedge clk);
        checkOutput("fl_rd_pulse", bus.fifo_read_en, 1);
        nextCycle();
        applyStimulus(1'b0, 1'b1);
        @(negedge clk);
        checkOutput("fl_rd_blocked", bus.fifo_read_en, 0);
        nextCycle();
        applyStimulus(1'b0, 1'b0);
        @(negedge clk);
        checkOutput("fl_valid_cleared", bus.m_valid, 0);
        nextCycle();
        applyStimulus(1'b1, 1'b0);
        waitForValid("fl_next", 10, cyc);
        checkOutput("fl_next_data", bus.m_data, 8'h53);
        drain();

        $display("[TB] asynchronous reset mid-stream");
        nextCycle();
        applyStimulus(1'b1, 1'b0);
        for (int i = 0; i < 10; i++) pushWord(DW'(8'hC0 + i));
        waitForValid("ar_setup", 10, cyc);
        repeat (2) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("ar_valid", bus.m_valid, 0);
        checkOutput("ar_rd_en", bus.fifo_read_en, 0);
        checkOutput("ar_data", bus.m_data, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        waitForValid("ar_restart", 10, cyc);
        drain();
        checkOutput("ar_src_consumed", popCount, pushCount);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            nextCycle();
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0);
            if ($urandom_range(0, 2) == 0 && (pushCount - popCount) < 900) pushWord(DW'($urandom));
        end
        drain();

`ifdef SYNC_FIFO_READER_CNT_EN
        $display("[TB] word counter wrap");
        doReset();
        applyStimulus(1'b1, 1'b0);
        for (int i = 0; i < 65534; i++) begin
            pushWord(DW'(i));
            nextCycle();
        end
        drain();
        checkOutput("cnt_preload", word_count, 16'hFFFE);
        for (int i = 0; i < 3; i++) pushWord(DW'(8'hE0 + i));
        drain();
        checkOutput("cnt_wrap", word_count, 16'h0001);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
